dispense_ctrl: RTL and testbench

- Vend-side stage downstream of the vending main controller; consumes a dispense request (item key plus start strobe) and the live credit from the coin counter.
- Looks up the item price and checks credit. On success it debits credit one nickel per cycle via a `down` strobe to the coin counter, then drives the selected vend motor for a fixed time.
- Reports a one-cycle success or fail pulse back to the main controller.

---
 rtl/vend_pkg.sv | 28 ++
 rtl/price_rom.sv | 21 ++
 rtl/dispense_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dispense_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state, fail-code and price constants for dispense_ctrl
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DEBIT,
    S_VEND,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_INVALID = 2'b01;
  localparam logic [1:0] FC_CREDIT  = 2'b10;
  localparam logic [1:0] FC_STOCK   = 2'b11;

  localparam logic [3:0] RETURN_KEY = 4'hF;

  localparam logic [5:0] PRICE_NONE = 6'd0;
  localparam logic [5:0] PRICE_LOW  = 6'd15;
  localparam logic [5:0] PRICE_MID  = 6'd20;
  localparam logic [5:0] PRICE_HIGH = 6'd25;

  localparam logic [3:0] STOCK_INIT = 4'd10;
  localparam int         NUM_ITEMS  = 12;

endpackage

// File: rtl/price_rom.sv
// rtl/price_rom.sv - combinational item key to nickel price lookup (0 = not vendable)
module price_rom
  import vend_pkg::*;
(
  input  logic [3:0] key,
  output logic [5:0] price
);

  always_comb begin
    price = PRICE_NONE;
    if (key != RETURN_KEY) begin
      case (key[3:2])
        2'd0:    price = PRICE_LOW;
        2'd1:    price = PRICE_MID;
        2'd2:    price = PRICE_HIGH;
        default: price = PRICE_NONE;
      endcase
    end
  end

endmodule

// File: rtl/dispense_ctrl.sv
// rtl/dispense_ctrl.sv - price check, nickel debit and timed motor drive; STOCK_TRACK_EN adds per-item stock
module dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 25000000,
  parameter int MCNT_W       = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] item_key,
  input  logic [5:0] coin_count,
`ifdef STOCK_TRACK_EN
  input  logic       restock,
`endif
  output logic       down,
  output logic       vend_on,
  output logic [3:0] vend_sel,
  output logic       busy,
  output logic       succeed,
  output logic       fail,
  output logic [1:0] fail_code
);

  state_t            state_q, state_d;
  logic [3:0]        key_q, key_d;
  logic [MCNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]        fcode_q, fcode_d;
  logic              down_q, down_d;
  logic              vend_on_q, vend_on_d;
  logic [3:0]        vend_sel_q, vend_sel_d;
  logic              busy_q, busy_d;
  logic              succeed_q, succeed_d;
  logic              fail_q, fail_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic [5:0]        price;
  logic              stock_empty;

  price_rom u_price_rom (
    .key   (key_q),
    .price (price)
  );

`ifdef STOCK_TRACK_EN
  logic [3:0] stock_q [16];
  logic [3:0] stock_d [16];

  assign stock_empty = (stock_q[key_q] == 4'd0);

  always_comb begin
    stock_d = stock_q;
    if (state_q == S_IDLE && restock) begin
      for (int i = 0; i < 16; i++) stock_d[i] = (i < NUM_ITEMS) ? STOCK_INIT : 4'd0;
    end else if (state_q == S_DONE && stock_q[key_q] != 4'd0) begin
      stock_d[key_q] = stock_q[key_q] - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) stock_q[i] <= (i < NUM_ITEMS) ? STOCK_INIT : 4'd0;
    end else begin
      stock_q <= stock_d;
    end
  end
`else
  assign stock_empty = 1'b0;
`endif

  // Outputs follow the current state one cycle late; busy also covers the
  // result-pulse cycle so an enable there is not taken.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    fcode_d     = fcode_q;
    down_d      = (state_q == S_DEBIT);
    vend_on_d   = (state_q == S_VEND);
    vend_sel_d  = (state_q == S_VEND) ? key_q : 4'd0;
    succeed_d   = (state_q == S_DONE);
    fail_d      = (state_q == S_FAIL);
    fail_code_d = (state_q == S_FAIL) ? fcode_q : fail_code_q;

    case (state_q)
      S_IDLE: begin
        if (enable && !busy_q) begin
          key_d   = item_key;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (price == PRICE_NONE) begin
          fcode_d = FC_INVALID;
          state_d = S_FAIL;
        end else if (coin_count < price) begin
          fcode_d = FC_CREDIT;
          state_d = S_FAIL;
        end else if (stock_empty) begin
          fcode_d = FC_STOCK;
          state_d = S_FAIL;
        end else begin
          cnt_d   = MCNT_W'(price);
          state_d = S_DEBIT;
        end
      end
      S_DEBIT: begin
        if (cnt_q == MCNT_W'(1)) begin
          cnt_d   = MCNT_W'(MOTOR_CYCLES);
          state_d = S_VEND;
        end else begin
          cnt_d = cnt_q - MCNT_W'(1);
        end
      end
      S_VEND: begin
        if (cnt_q == MCNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - MCNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      fcode_q     <= FC_NONE;
      down_q      <= 1'b0;
      vend_on_q   <= 1'b0;
      vend_sel_q  <= '0;
      busy_q      <= 1'b0;
      succeed_q   <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= FC_NONE;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      fcode_q     <= fcode_d;
      down_q      <= down_d;
      vend_on_q   <= vend_on_d;
      vend_sel_q  <= vend_sel_d;
      busy_q      <= busy_d;
      succeed_q   <= succeed_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign down      = down_q;
  assign vend_on   = vend_on_q;
  assign vend_sel  = vend_sel_q;
  assign busy      = busy_q;
  assign succeed   = succeed_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_dispense_ctrl.sv
// tb/tb_dispense_ctrl.sv - vector table, random requests vs price/credit/stock model, reset and enable corner cases
module tb_dispense_ctrl;

  localparam int MOTOR = 8;
  localparam int BOUND = 80;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] item_key;
  logic [5:0] coin_count;
  logic       restock;
  logic       down, vend_on, busy, succeed, fail;
  logic [3:0] vend_sel;
  logic [1:0] fail_code;

  always #5 clk = ~clk;

  dispense_ctrl #(.MOTOR_CYCLES(MOTOR), .MCNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .item_key   (item_key),
    .coin_count (coin_count),
`ifdef STOCK_TRACK_EN
    .restock    (restock),
`endif
    .down       (down),
    .vend_on    (vend_on),
    .vend_sel   (vend_sel),
    .busy       (busy),
    .succeed    (succeed),
    .fail       (fail),
    .fail_code  (fail_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int last_code;
  int stock [16];

  // Observations of the last transaction
  int r_done, r_succ, r_failp, r_code, r_lat, r_downs, r_vends;
  int r_overlap, r_selerr, r_busy_gap, r_busy_post;

  typedef struct {
    logic [3:0] key;
    logic [5:0] coin;
    bit         exp_ok;
    int         exp_code;
    int         exp_downs;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int price_of(input int key);
    if (key >= 12) return 0;
    return 15 + 5 * (key / 4);
  endfunction

  function automatic bit stock_tracked();
`ifdef STOCK_TRACK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    last_code = 0;
    for (int i = 0; i < 16; i++) stock[i] = (i < 12) ? 10 : 0;
  endtask

  task automatic run_txn(input logic [3:0] key, input logic [5:0] coin,
                         input int extra_at, input bit pulse_on_done);
    int post;
    bit pulsed;
    r_done = 0; r_succ = 0; r_failp = 0; r_code = -1; r_lat = -1;
    r_downs = 0; r_vends = 0; r_overlap = 0; r_selerr = 0;
    r_busy_gap = 0; r_busy_post = 0;
    post = 0;
    pulsed = 0;
    item_key   = key;
    coin_count = coin;
    enable     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    for (int cyc = 1; cyc <= BOUND && post < 3; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (down) r_downs++;
      if (vend_on) r_vends++;
      if (down && vend_on) r_overlap++;
      if (vend_on ? (vend_sel != key) : (vend_sel != 4'd0)) r_selerr++;
      if (!r_done && !busy) r_busy_gap++;
      if (r_done && busy) r_busy_post++;
      if (succeed) begin
        r_succ++;
        if (!r_done) r_lat = cyc;
      end
      if (fail) begin
        r_failp++;
        if (!r_done) begin
          r_lat  = cyc;
          r_code = int'(fail_code);
        end
      end
      if (r_done) post++;
      enable   = 1'b0;
      item_key = key;
      if (cyc == extra_at) begin
        enable   = 1'b1;
        item_key = ~key;
      end
      if (pulse_on_done && !pulsed && (succeed || fail)) begin
        enable = 1'b1;
        pulsed = 1;
      end
      if (succeed || fail) r_done = 1;
    end
    enable   = 1'b0;
    item_key = key;
  endtask

  task automatic verify(input string tag, input int key, input bit exp_ok,
                        input int exp_code, input int exp_downs);
    check({tag, " completed"}, r_done, 1);
    check({tag, " succeed pulses"}, r_succ, exp_ok ? 1 : 0);
    check({tag, " fail pulses"}, r_failp, exp_ok ? 0 : 1);
    check({tag, " latency"}, r_lat, exp_ok ? (2 + exp_downs + MOTOR) : 2);
    check({tag, " down cycles"}, r_downs, exp_downs);
    check({tag, " vend cycles"}, r_vends, exp_ok ? MOTOR : 0);
    if (!exp_ok) check({tag, " fail_code"}, r_code, exp_code);
    check({tag, " down/vend overlap"}, r_overlap, 0);
    check({tag, " vend_sel errors"}, r_selerr, 0);
    check({tag, " busy gap"}, r_busy_gap, 0);
    check({tag, " busy after result"}, r_busy_post, 0);
    if (exp_ok) begin
      if (stock[key] > 0) stock[key]--;
    end else begin
      last_code = exp_code;
    end
    check({tag, " fail_code held"}, int'(fail_code), last_code);
  endtask

  task automatic do_txn(input string tag, input logic [3:0] key, input logic [5:0] coin,
                        input int extra_at, input bit pulse_on_done);
    int  p;
    bit  ok;
    int  code;
    p = price_of(int'(key));
    ok = 0;
    code = 0;
    if (p == 0) code = 1;
    else if (int'(coin) < p) code = 2;
    else if (stock_tracked() && stock[key] == 0) code = 3;
    else ok = 1;
    run_txn(key, coin, extra_at, pulse_on_done);
    verify(tag, int'(key), ok, code, ok ? p : 0);
  endtask

  task automatic pulse_restock();
    restock = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restock = 1'b0;
    for (int i = 0; i < 12; i++) stock[i] = 10;
  endtask

  initial begin
    vecs[0]  = '{4'd3,  6'd20, 1'b1, 0, 15};
    vecs[1]  = '{4'd9,  6'd24, 1'b0, 2, 0};
    vecs[2]  = '{4'd15, 6'd63, 1'b0, 1, 0};
    vecs[3]  = '{4'd13, 6'd63, 1'b0, 1, 0};
    vecs[4]  = '{4'd4,  6'd20, 1'b1, 0, 20};
    vecs[5]  = '{4'd0,  6'd14, 1'b0, 2, 0};
    vecs[6]  = '{4'd0,  6'd15, 1'b1, 0, 15};
    vecs[7]  = '{4'd11, 6'd25, 1'b1, 0, 25};
    vecs[8]  = '{4'd12, 6'd63, 1'b0, 1, 0};
    vecs[9]  = '{4'd7,  6'd0,  1'b0, 2, 0};
    vecs[10] = '{4'd8,  6'd63, 1'b1, 0, 25};

    reset_n    = 1'b0;
    enable     = 1'b0;
    item_key   = 4'd0;
    coin_count = 6'd0;
    restock    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset down", int'(down), 0);
    check("reset vend_on", int'(vend_on), 0);
    check("reset vend_sel", int'(vend_sel), 0);
    check("reset busy", int'(busy), 0);
    check("reset succeed", int'(succeed), 0);
    check("reset fail", int'(fail), 0);
    check("reset fail_code", int'(fail_code), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].key, vecs[i].coin, 0, 1'b0);
      verify($sformatf("vec%0d", i), int'(vecs[i].key), vecs[i].exp_ok,
             vecs[i].exp_code, vecs[i].exp_downs);
    end

    // Second enable mid-DEBIT is dropped, no queued request follows
    do_txn("exact credit w/ mid-debit enable", 4'd4, 6'd20, 6, 1'b0);
    // Enable during the result-pulse cycle is ignored
    do_txn("enable on return cycle", 4'd1, 6'd40, 0, 1'b1);
    do_txn("fail then enable on return", 4'd10, 6'd3, 0, 1'b1);

    // Reset held for 3 cycles while the motor runs
    begin
      int seen;
      seen = 0;
      item_key   = 4'd3;
      coin_count = 6'd20;
      enable     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      for (int c = 0; c < BOUND && seen == 0; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (vend_on) seen = 1;
      end
      check("mid-vend reached", seen, 1);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid-vend reset vend_on", int'(vend_on), 0);
      check("mid-vend reset busy", int'(busy), 0);
      check("mid-vend reset down", int'(down), 0);
      check("mid-vend reset vend_sel", int'(vend_sel), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      do_txn("after reset", 4'd2, 6'd15, 0, 1'b0);
    end

    for (int i = 0; i < 25; i++) begin
      logic [3:0] k;
      logic [5:0] c;
      k = 4'($urandom_range(15, 0));
      c = 6'($urandom_range(63, 0));
      do_txn($sformatf("rand%0d", i), k, c, 0, 1'b0);
    end

`ifdef STOCK_TRACK_EN
    pulse_restock();
    for (int i = 0; i < 10; i++) do_txn($sformatf("stock vend%0d", i), 4'd0, 6'd63, 0, 1'b0);
    check("stock model empty", stock[0], 0);
    do_txn("out of stock", 4'd0, 6'd63, 0, 1'b0);
    check("out of stock code", r_code, 3);
    pulse_restock();
    do_txn("after restock", 4'd0, 6'd63, 0, 1'b0);
    check("after restock succeed", r_succ, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
